// File: rtl/reg_file_pkg.sv
// Shared sizing defaults and readout state encoding for the register file reader.
package reg_file_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } dump_state_e;

endpackage

// File: rtl/reg_file_dump_ctrl.sv
// Sequential readout controller: walks dump_addr 0..2**ADDR_W-1, one beat per cycle.
module reg_file_dump_ctrl
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_start,
    output logic              beat_en_c,
    output logic [ADDR_W-1:0] beat_addr_c,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    dump_state_e state;

    // Beat that the coming edge will present; start requests are only honoured from IDLE.
    always_comb begin
        beat_en_c   = 1'b0;
        beat_addr_c = '0;
        case (state)
            IDLE: beat_en_c = dump_start;
            DUMP: begin
                beat_en_c   = (dump_addr != LAST_ADDR);
                beat_addr_c = dump_addr + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
        end else begin
            state      <= beat_en_c ? DUMP : IDLE;
            dump_busy  <= beat_en_c;
            dump_valid <= beat_en_c;
            dump_addr  <= beat_en_c ? beat_addr_c : '0;
        end
    end

endmodule

// File: rtl/reg_file_reader.sv
// Register file with two registered read ports and a sequential dump port.
// Define REG_FILE_BYPASS_EN to forward same-edge write data to colliding reads.
module reg_file_reader
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic [ADDR_W-1:0] inaddr,
    input  logic              write,
    input  logic [ADDR_W-1:0] out1addr,
    input  logic [ADDR_W-1:0] out2addr,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic              beat_en_c;
    logic [ADDR_W-1:0] beat_addr_c;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;
    logic [DATA_W-1:0] rdd_c;

    reg_file_dump_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_dump_ctrl (
        .clk         (clk),
        .reset       (reset),
        .dump_start  (dump_start),
        .beat_en_c   (beat_en_c),
        .beat_addr_c (beat_addr_c),
        .dump_busy   (dump_busy),
        .dump_valid  (dump_valid),
        .dump_addr   (dump_addr)
    );

    // Read muxes; with bypass a same-edge write to the read address wins.
    assign rd1_c = (BYPASS && write && (inaddr == out1addr))    ? in : mem[out1addr];
    assign rd2_c = (BYPASS && write && (inaddr == out2addr))    ? in : mem[out2addr];
    assign rdd_c = (BYPASS && write && (inaddr == beat_addr_c)) ? in : mem[beat_addr_c];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            out1      <= '0;
            out2      <= '0;
            dump_data <= '0;
        end else begin
            if (write) begin
                mem[inaddr] <= in;
            end
            out1      <= rd1_c;
            out2      <= rd2_c;
            dump_data <= beat_en_c ? rdd_c : '0;
        end
    end

endmodule
